// File: rtl/aes_128to4.sv
// Output serializer for the AES datapath: captures a 128-bit result on done and
// streams it MSB-first, one nibble per valid/ready beat, with a one-deep pending buffer.
module aes_128to4 #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned NIB_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done,
  input  logic [DATA_W-1:0] text_out,
  output logic [NIB_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              overrun
);

  localparam int unsigned NIBBLES = DATA_W / NIB_W;
  localparam int unsigned CNT_W   = $clog2(NIBBLES);
  localparam int unsigned LAST    = NIBBLES - 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DATA_W-1:0]   sreg;
  logic [DATA_W-1:0]   pend;
  logic                pend_valid;
  logic [CNT_W-1:0]    count;
  logic                xfer;
  logic                last_xfer;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: leave SHIFT only when the final beat goes and nothing is queued behind it
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (done) state_nxt = SHIFT;
      SHIFT: if (last_xfer && !pend_valid && !done) state_nxt = IDLE;
    endcase
  end

  // Output decode from registered state; data is forced to zero when not valid
  always_comb begin
    out_valid = (state == SHIFT);
    out_data  = out_valid ? sreg[DATA_W-1 -: NIB_W] : '0;
    out_last  = out_valid && (count == CNT_W'(LAST));
    busy      = out_valid || pend_valid;
  end

  assign xfer      = out_valid && out_ready;
  assign last_xfer = xfer && (count == CNT_W'(LAST));

  // Shifter, beat counter, pending buffer and sticky overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg       <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      count      <= '0;
      overrun    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (done) begin
            sreg  <= text_out;
            count <= '0;
          end
        end
        SHIFT: begin
          if (last_xfer) begin
            count <= '0;
            if (pend_valid) begin
              sreg <= pend;
              if (done) pend       <= text_out;
              else      pend_valid <= 1'b0;
            end else if (done) begin
              sreg <= text_out;
            end
          end else begin
            if (xfer) begin
              sreg  <= {sreg[DATA_W-NIB_W-1:0], {NIB_W{1'b0}}};
              count <= count + CNT_W'(1);
            end
            if (done) begin
              if (!pend_valid) begin
                pend       <= text_out;
                pend_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_128to4.sv
// Self-checking bench for aes_128to4: word-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_aes_128to4;

  localparam logic [127:0] FIPS = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] W2   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] W3   = 128'hdeadbeef0123456789abcdef55aa33cc;
  localparam logic [127:0] ONES = {128{1'b1}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         done = 1'b0;
  logic [127:0] text_out = '0;
  logic [3:0]   out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_last;
  logic         busy;
  logic         overrun;

  aes_128to4 dut (
    .clk(clk), .rst(rst), .done(done), .text_out(text_out),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: queue of nibbles still owed to the consumer
  logic [3:0] q[$];
  logic       m_ovr = 1'b0;
  bit         m_live = 1'b0;

  logic [3:0] collected[$];
  int         last_cnt = 0;

  int ready_mode = 0;  // 0: always 1, 1: pattern 1,0,0,1, 2: random, 3: always 0
  int pidx = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word is owed until all 32 nibbles leave; at most two words may be owed
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        m_ovr  = 1'b0;
        m_live = 1'b1;
      end else begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (done) begin
          if ((q.size() + 31) / 32 < 2) begin
            for (int k = 0; k < 32; k++) q.push_back(text_out[127-4*k -: 4]);
          end else begin
            m_ovr = 1'b1;
          end
        end
      end
    end
  end

  // Per-cycle compare and beat collection, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        logic       ev;
        logic [3:0] ed;
        ev = (q.size() > 0);
        ed = ev ? q[0] : 4'h0;
        check("out_valid", 128'(out_valid), 128'(ev));
        check("out_data",  128'(out_data),  128'(ed));
        check("out_last",  128'(out_last),  128'(ev && (q.size() % 32 == 1)));
        check("busy",      128'(busy),      128'(ev));
        check("overrun",   128'(overrun),   128'(m_ovr));
      end
      if (out_valid && out_ready) begin
        collected.push_back(out_data);
        if (out_last) last_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    done = 1'b0;
    pidx++;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = (pidx % 4 == 0) || (pidx % 4 == 3);
      2: out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  endtask

  task automatic pulse(input logic [127:0] w);
    done = 1'b1;
    text_out = w;
    step();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 600 && busy; i++) step();
    check("idle_timeout", 128'(busy), 128'(0));
  endtask

  function automatic logic [127:0] word_at(input int base);
    logic [127:0] w;
    w = '0;
    for (int k = 0; k < 32; k++)
      if (base + k < collected.size()) w[127-4*k -: 4] = collected[base+k];
    return w;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    collected.delete();
    last_cnt = 0;
  endtask

  initial begin
    // Reset state
    ready_mode = 0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_valid", 128'(out_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_overrun", 128'(overrun), 128'(0));
    check("rst_data", 128'(out_data), 128'(0));
    collected.delete();
    last_cnt = 0;

    // FIPS-197 vector, continuous ready
    pulse(FIPS);
    check("fips_lat_valid", 128'(out_valid), 128'(1));
    check("fips_beat0", 128'(out_data), 128'h6);
    wait_idle();
    check("fips_count", 128'(collected.size()), 128'(32));
    if (collected.size() == 32) begin
      check("fips_b1", 128'(collected[1]), 128'h9);
      check("fips_b31", 128'(collected[31]), 128'ha);
    end
    check("fips_word", word_at(0), FIPS);
    check("fips_last", 128'(last_cnt), 128'(1));

    // Backpressure 1,0,0,1
    collected.delete(); last_cnt = 0;
    ready_mode = 1; pidx = 0;
    pulse(FIPS);
    wait_idle();
    check("bp_count", 128'(collected.size()), 128'(32));
    check("bp_word", word_at(0), FIPS);

    // Back-to-back: second word queued mid-stream
    collected.delete(); last_cnt = 0;
    ready_mode = 0;
    pulse(FIPS);
    repeat (5) step();
    pulse(W2);
    wait_idle();
    check("b2b_count", 128'(collected.size()), 128'(64));
    check("b2b_w0", word_at(0), FIPS);
    check("b2b_w1", word_at(32), W2);
    check("b2b_last", 128'(last_cnt), 128'(2));

    // Overrun: three words against a stalled stream
    collected.delete(); last_cnt = 0;
    ready_mode = 3;
    step();
    pulse(FIPS);
    repeat (2) step();
    pulse(W2);
    repeat (2) step();
    pulse(W3);
    check("ovr_flag", 128'(overrun), 128'(1));
    ready_mode = 0;
    wait_idle();
    check("ovr_count", 128'(collected.size()), 128'(64));
    check("ovr_w0", word_at(0), FIPS);
    check("ovr_w1", word_at(32), W2);
    check("ovr_sticky", 128'(overrun), 128'(1));
    do_reset();

    // done coincident with the beat-31 transfer, nothing pending
    ready_mode = 0;
    pulse(FIPS);
    repeat (31) step();
    pulse(W3);
    check("bnd_valid", 128'(out_valid), 128'(1));
    check("bnd_data", 128'(out_data), 128'hd);
    wait_idle();
    check("bnd_count", 128'(collected.size()), 128'(64));
    check("bnd_w1", word_at(32), W3);

    // Reset mid-stream with a pending word
    pulse(FIPS);
    repeat (4) step();
    pulse(W2);
    repeat (5) step();
    do_reset();
    check("mrst_valid", 128'(out_valid), 128'(0));
    check("mrst_busy", 128'(busy), 128'(0));
    check("mrst_overrun", 128'(overrun), 128'(0));
    pulse(ONES);
    wait_idle();
    check("mrst_count", 128'(collected.size()), 128'(32));
    check("mrst_word", word_at(0), ONES);

    // Random traffic against the model
    ready_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) begin
        done = 1'b1;
        text_out = {$urandom, $urandom, $urandom, $urandom};
      end
      step();
    end
    ready_mode = 0;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_128to4.md
Name: aes_128to4

Overview:
Output-side serializer for the AES datapath. It captures a 128-bit result from the AES core on the core's done pulse and streams it out 4 bits per beat over a valid/ready handshake. It mirrors the input-side 4-to-128 deserializer. A one-deep pending buffer absorbs a second result that arrives while a stream is still in progress.

Parameters:
DATA_W, 128, width of captured result
NIB_W, 4, width of each output beat
NIBBLES, DATA_W/NIB_W (32), beats per result; count width = clog2(NIBBLES) = 5

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
done  input  1  single-cycle pulse from AES core; text_out valid in the same cycle
text_out  input  DATA_W  result word from AES core
out_data  output  NIB_W  current beat; 4'h0 whenever out_valid=0
out_valid  output  1  beat available
out_ready  input  1  consumer accepts beat
out_last  output  1  high with the final beat (count==NIBBLES-1) while out_valid=1
busy  output  1  state!=IDLE or pend_valid
overrun  output  1  sticky; a result was dropped

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, shift register=0, count=0, pend_valid=0, pending buffer=0, overrun=0. All outputs are 0 from the following cycle.
- Reset mid-stream aborts both the current and the pending word; no beats are emitted after it.
- Beat order is MSB first: beat k = text_out[DATA_W-1-4k -: 4], so beat 0 = [127:124] and beat 31 = [3:0].
- Transfer occurs when out_valid && out_ready at a clock edge.
- States: IDLE and SHIFT.
- IDLE:
  - out_valid=0.
  - On done: shift register <= text_out, count <= 0, go to SHIFT.
  - out_valid=1 from the next cycle. Latency from done to first beat is 1 cycle.
- SHIFT:
  - out_valid=1; out_data = shift register [DATA_W-1 -: NIB_W].
  - On a transfer with count<31: shift left by NIB_W, count++.
  - With no transfer (stall): out_data, out_last and count hold.
- Final transfer (count==31):
  - If pend_valid: load the pending word into the shift register, count <= 0, pend_valid <= 0, stay in SHIFT. No bubble cycle.
  - Else if done in the same cycle: load text_out directly, count <= 0, stay in SHIFT. No bubble cycle.
  - Else: go to IDLE; out_valid=0 next cycle.
- done while in SHIFT, not on a final transfer:
  - pend_valid=0: pending <= text_out, pend_valid <= 1.
  - pend_valid=1: the word is dropped and overrun <= 1.
- done on a final transfer with pend_valid=1: the pending word moves to the shifter and text_out goes to pending (pend_valid stays 1). No overrun.
- done during IDLE while pend_valid=1 cannot occur; the pending buffer is always drained before returning to IDLE.
- overrun clears only on rst.
- A done pulse held for multiple cycles is treated as multiple results. The upstream core guarantees single-cycle pulses.

Test Plan:
- FIPS-197 vector: done with text_out=128'h69c4e0d86a7b0430d8cdb78070b4c55a, out_ready=1 -> out_valid rises 1 cycle later; beats 6,9,c,4,e,0,…,5,5,a on 32 consecutive cycles; out_last only on beat 'a'; IDLE and busy=0 afterwards.
- Backpressure, same vector with out_ready toggling 1,0,0,1 repeating -> identical 32-beat sequence; no loss or duplication; out_data stable during stalls.
- Back-to-back: second done with 128'h00112233445566778899aabbccddeeff at beat 5 of the first stream, out_ready=1 -> 64 contiguous valid beats; beat 32 = 0; no gap; single out_last at beats 31 and 63.
- Overrun: three dones, at cycles 0, 3 and 6 of a stalled stream -> overrun=1; only the first two words are emitted; the third is absent.
- Boundary: done coincident with the beat-31 transfer and pend_valid=0 -> next cycle out_valid=1 with beat 0 of the new word.
- Reset: rst=1 at beat 10 with pend_valid=1 -> next cycle out_valid=0, busy=0, overrun=0. A later done with 128'hFFFF…FF emits 32 beats of 'f' starting at beat 0.
